spi_regfile_sink: RTL and testbench

System-clocked SPI target that emulates an MCP23S17-style register device with a parametrised register file, multi-byte sequential access and device-address matching. It oversamples SPI mode-0 signals from an external SPI source on the fabric clock, so all state lives in one clock domain. It sits behind the board SPI pins and exposes the register contents and write events to fabric logic. Fabric logic can also load registers, for example to emulate GPIO input pins.

---
 rtl/spi_regfile_sink.sv | 201 ++++++++++++++++++++
 tb/tb_spi_regfile_sink.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_sink.sv
// MCP23S17-style SPI target: oversampled mode-0 SPI on clk, parametrised byte register file,
// sequential access with wrap, device-address matching and a fabric-side load port.
module spi_regfile_sink #(
   parameter int unsigned NUM_REGS = 22,
   parameter logic [2:0]  DEV_ADDR = 3'b000,
   parameter logic [3:0]  OPC_BASE = 4'b0100,
   parameter bit          SEQ_EN   = 1'b1,
   parameter logic [7:0]  RST_VAL  = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk_i,
   input  logic                  csn_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   output logic [8*NUM_REGS-1:0] reg_q,
   output logic                  wr_stb_o,
   output logic [7:0]            wr_addr_o,
   output logic [7:0]            wr_data_o,
   input  logic                  ld_en_i,
   input  logic [7:0]            ld_addr_i,
   input  logic [7:0]            ld_data_i
);

   localparam logic [8:0] NREGS9   = 9'(NUM_REGS);
   localparam logic [7:0] LAST_PTR = 8'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      ADDR,
      WDATA,
      RDATA,
      IGNORE
   } state_t;

   function automatic logic in_range(input logic [7:0] p);
      return ({1'b0, p} < NREGS9);
   endfunction

   function automatic logic [7:0] next_ptr(input logic [7:0] p);
      if (!SEQ_EN)
         return p;
      else if (p == LAST_PTR)
         return 8'h00;
      else
         return p + 8'h01;
   endfunction

   // Stage 0/1: two-flop synchronizers; stage 2 holds the previous synchronized level
   logic [2:0] sclk_sync_q;
   logic [2:0] csn_sync_q;
   logic [1:0] mosi_sync_q;

   always_ff @(posedge clk) begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      csn_sync_q  <= {csn_sync_q[1:0], csn_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
   end

   logic sclk_rise, sclk_fall, csn_s, csn_fall, mosi_s;
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign csn_s     = csn_sync_q[1];
   assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];

   // Stage 3: frame FSM, shifters and register file
   state_t                state_q, state_d;
   logic [2:0]            bitcnt_q, bitcnt_d;
   logic [6:0]            shift_q, shift_d;
   logic                  rd_q, rd_d;
   logic [7:0]            ptr_q, ptr_d;
   logic [6:0]            tx_q, tx_d;
   logic                  miso_q, miso_d;
   logic                  oe_q, oe_d;
   logic                  wr_stb_q;
   logic [7:0]            wr_addr_q, wr_data_q;
   logic [8*NUM_REGS-1:0] regfile_q;

   logic [7:0] rx_byte;
   logic [7:0] rd_data;
   logic       commit;
   logic       ld_ok;

   assign rx_byte = {shift_q, mosi_s};
   assign ld_ok   = ld_en_i & in_range(ld_addr_i);

   // Out-of-range pointers read back as zero because no register matches them.
   always_comb begin
      rd_data = 8'h00;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (ptr_q == 8'(k))
            rd_data = regfile_q[8*k +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      rd_d     = rd_q;
      ptr_d    = ptr_q;
      tx_d     = tx_q;
      miso_d   = miso_q;
      oe_d     = oe_q;
      commit   = 1'b0;

      if (csn_s) begin
         state_d  = IDLE;
         bitcnt_d = 3'd7;
         miso_d   = 1'b0;
         oe_d     = 1'b0;
      end else if (state_q == IDLE) begin
         if (csn_fall) begin
            state_d  = OPCODE;
            bitcnt_d = 3'd7;
         end
      end else begin
         if (sclk_rise) begin
            shift_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q - 3'd1;
            if (bitcnt_q == 3'd0) begin
               case (state_q)
                  OPCODE: begin
                     rd_d = rx_byte[0];
                     if (rx_byte[7:4] == OPC_BASE && rx_byte[3:1] == DEV_ADDR)
                        state_d = ADDR;
                     else
                        state_d = IGNORE;
                  end
                  ADDR: begin
                     ptr_d   = rx_byte;
                     state_d = rd_q ? RDATA : WDATA;
                  end
                  WDATA: begin
                     commit = in_range(ptr_q);
                     ptr_d  = next_ptr(ptr_q);
                  end
                  RDATA: ptr_d = next_ptr(ptr_q);
                  default: ;
               endcase
            end
         end
         // A falling event with the counter back at 7 marks a byte boundary.
         if (sclk_fall && state_q == RDATA) begin
            if (bitcnt_q == 3'd7) begin
               miso_d = rd_data[7];
               tx_d   = rd_data[6:0];
               oe_d   = 1'b1;
            end else begin
               miso_d = tx_q[6];
               tx_d   = {tx_q[5:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      rd_q    <= rd_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      if (rst) begin
         state_q   <= IDLE;
         bitcnt_q  <= 3'd7;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         regfile_q <= {NUM_REGS{RST_VAL}};
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         miso_q   <= miso_d;
         oe_q     <= oe_d;
         wr_stb_q <= commit;
         if (commit) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= rx_byte;
         end
         // SPI commit takes priority over a fabric load to the same register.
         for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && ptr_q == 8'(k))
               regfile_q[8*k +: 8] <= rx_byte;
            else if (ld_ok && ld_addr_i == 8'(k))
               regfile_q[8*k +: 8] <= ld_data_i;
         end
      end
   end

   assign miso_o    = miso_q;
   assign miso_oe_o = oe_q;
   assign reg_q     = regfile_q;
   assign wr_stb_o  = wr_stb_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_spi_regfile_sink.sv
// Directed bench for spi_regfile_sink: an SPI master drives frames while a frame-level
// register/strobe model predicts register contents, strobes and returned read bytes.
module tb_spi_regfile_sink;
   localparam int NR   = 22;
   localparam int HALF = 6;

   logic            clk = 1'b0;
   logic            rst, sclk, csn, mosi, miso, miso_oe;
   logic [8*NR-1:0] regs;
   logic            wr_stb;
   logic [7:0]      wr_addr, wr_data;
   logic            ld_en;
   logic [7:0]      ld_addr, ld_data;

   int n_checks = 0;
   int n_errs   = 0;
   bit quiet    = 1'b0;
   int stb_seen = 0;

   logic [7:0] m_regs [NR];
   int         exp_wa [$];
   logic [7:0] exp_wd [$];
   logic [7:0] tx_buf [16];
   logic [7:0] rx_buf [16];
   bit         oe_any [16];
   bit         oe_all [16];
   logic [7:0] exp_rd [16];
   bit         exp_oe [16];
   logic [7:0] coll_addr, coll_data;
   int         mon_wa;
   logic [7:0] mon_wd;
   int         bad;

   spi_regfile_sink #(
      .NUM_REGS(NR), .DEV_ADDR(3'b000), .OPC_BASE(4'b0100), .SEQ_EN(1'b1), .RST_VAL(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
      .miso_o(miso), .miso_oe_o(miso_oe), .reg_q(regs),
      .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rg(input int k);
      return regs[8*k +: 8];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_stb) begin
            stb_seen++;
            if (exp_wa.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL unexpected_strobe: got addr %0h data %0h, required no strobe", wr_addr, wr_data);
            end else begin
               mon_wa = exp_wa.pop_front();
               mon_wd = exp_wd.pop_front();
               chk("stb_addr", 32'(wr_addr), 32'(mon_wa));
               chk("stb_data", 32'(wr_data), 32'(mon_wd));
            end
         end
         if (quiet) begin
            bad = -1;
            for (int k = NR - 1; k >= 0; k--)
               if (regs[8*k +: 8] !== m_regs[k]) bad = k;
            n_checks++;
            if (bad >= 0) begin
               n_errs++;
               $display("FAIL regfile[%0d]: got %0h, required %0h", bad, regs[8*bad +: 8], m_regs[bad]);
            end
            chk("idle_oe", 32'(miso_oe), 32'd0);
         end
      end
   end

   // Frame-level model: what an MCP23S17-like device does with a completed byte list.
   task automatic model_frame(input int n, input bit coll);
      logic [7:0] op;
      bit         matched, rd, wrote_last;
      int         p, last_p;
      op = tx_buf[0];
      matched = (n >= 2) && (op[7:4] == 4'b0100) && (op[3:1] == 3'b000);
      rd = op[0];
      p = int'(tx_buf[1]);
      last_p = -1;
      wrote_last = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_rd[i] = 8'h00;
         exp_oe[i] = 1'b0;
      end
      if (matched) begin
         for (int i = 2; i < n; i++) begin
            wrote_last = 1'b0;
            if (rd) begin
               exp_oe[i] = 1'b1;
               exp_rd[i] = (p < NR) ? m_regs[p] : 8'h00;
            end else if (p < NR) begin
               m_regs[p] = tx_buf[i];
               exp_wa.push_back(p);
               exp_wd.push_back(tx_buf[i]);
               wrote_last = 1'b1;
            end
            last_p = p;
            p = (p == NR - 1) ? 0 : ((p + 1) % 256);
         end
      end
      if (coll && int'(coll_addr) < NR && !(wrote_last && int'(coll_addr) == last_p))
         m_regs[int'(coll_addr)] = coll_data;
   endtask

   task automatic send_bits(input logic [7:0] b, input int nb, input int idx, input bit coll);
      logic [7:0] r;
      bit any, all;
      r = 8'h00;
      any = 1'b0;
      all = 1'b1;
      for (int k = 0; k < nb; k++) begin
         mosi = b[7-k];
         tick(HALF);
         sclk = 1'b1;
         r = {r[6:0], miso};
         any = any | miso_oe;
         all = all & miso_oe;
         if (coll && k == nb - 1) begin
            tick(2);
            ld_en = 1'b1;
            ld_addr = coll_addr;
            ld_data = coll_data;
            tick(1);
            ld_en = 1'b0;
            tick(HALF - 3);
         end else begin
            tick(HALF);
         end
         sclk = 1'b0;
      end
      rx_buf[idx] = r;
      oe_any[idx] = any;
      oe_all[idx] = all;
   endtask

   task automatic run_frame(input int n, input int abort_bits, input bit coll);
      quiet = 1'b0;
      model_frame(n, coll);
      csn = 1'b0;
      tick(HALF);
      for (int i = 0; i < n; i++)
         send_bits(tx_buf[i], 8, i, coll && (i == n - 1));
      if (abort_bits > 0)
         send_bits(tx_buf[n], abort_bits, n, 1'b0);
      tick(HALF);
      csn = 1'b1;
      tick(8);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("rx_byte%0d", i), 32'(rx_buf[i]), 32'(exp_rd[i]));
         if (exp_oe[i]) chk($sformatf("oe_on_byte%0d", i), 32'(oe_all[i]), 32'd1);
         else           chk($sformatf("oe_off_byte%0d", i), 32'(oe_any[i]), 32'd0);
      end
      chk("oe_after_frame", 32'(miso_oe), 32'd0);
      chk("miso_after_frame", 32'(miso), 32'd0);
      chk("strobes_pending", 32'(exp_wa.size()), 32'd0);
      tick(2);
      quiet = 1'b1;
      tick(4);
   endtask

   task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
      tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3; tx_buf[4] = b4;
   endtask

   task automatic fab_load(input logic [7:0] a, input logic [7:0] d);
      quiet = 1'b0;
      ld_en = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick(1);
      ld_en = 1'b0;
      if (int'(a) < NR) m_regs[int'(a)] = d;
      tick(2);
      quiet = 1'b1;
      tick(2);
   endtask

   int s0;

   initial begin
      rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
      ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
      coll_addr = 8'h00; coll_data = 8'h00;
      for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
      for (int i = 0; i < 16; i++) tx_buf[i] = 8'h00;
      tick(5);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_oe", 32'(miso_oe), 32'd0);
      chk("rst_stb", 32'(wr_stb), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_reg0", 32'(rg(0)), 32'd0);
      chk("rst_reg21", 32'(rg(21)), 32'd0);
      rst = 1'b0;
      tick(4);
      quiet = 1'b1;
      tick(2);

      // single write
      s0 = stb_seen;
      set_tx(8'h40, 8'h05, 8'hA5, 8'h00, 8'h00);
      run_frame(3, 0, 1'b0);
      chk("w1_reg5", 32'(rg(5)), 32'hA5);
      chk("w1_strobes", 32'(stb_seen - s0), 32'd1);
      chk("w1_wr_addr", 32'(wr_addr), 32'h05);
      chk("w1_wr_data", 32'(wr_data), 32'hA5);

      // sequential write across the top register
      s0 = stb_seen;
      set_tx(8'h40, 8'h14, 8'h11, 8'h22, 8'h33);
      run_frame(5, 0, 1'b0);
      chk("seq_reg20", 32'(rg(20)), 32'h11);
      chk("seq_reg21", 32'(rg(21)), 32'h22);
      chk("seq_reg0", 32'(rg(0)), 32'h33);
      chk("seq_strobes", 32'(stb_seen - s0), 32'd3);

      // fabric preload then read
      fab_load(8'h03, 8'h3C);
      fab_load(8'h40, 8'hEE);
      set_tx(8'h41, 8'h03, 8'h00, 8'h00, 8'h00);
      run_frame(4, 0, 1'b0);
      chk("rd_byte_reg3", 32'(rx_buf[2]), 32'h3C);
      chk("rd_byte_reg4", 32'(rx_buf[3]), 32'h00);

      // non-matching device address
      s0 = stb_seen;
      set_tx(8'h42, 8'h06, 8'h77, 8'h00, 8'h00);
      run_frame(3, 0, 1'b0);
      chk("ign_strobes", 32'(stb_seen - s0), 32'd0);
      chk("ign_reg6", 32'(rg(6)), 32'h00);

      // out-of-range write and read
      s0 = stb_seen;
      set_tx(8'h40, 8'h30, 8'h55, 8'h00, 8'h00);
      run_frame(3, 0, 1'b0);
      chk("oor_w_strobes", 32'(stb_seen - s0), 32'd0);
      set_tx(8'h41, 8'h30, 8'h00, 8'h00, 8'h00);
      run_frame(4, 0, 1'b0);
      chk("oor_rd_byte", 32'(rx_buf[2]), 32'h00);
      chk("oor_rd_oe", 32'(oe_all[2]), 32'd1);

      // abort mid data byte, then a normal frame
      s0 = stb_seen;
      set_tx(8'h40, 8'h07, 8'hFF, 8'h00, 8'h00);
      run_frame(2, 4, 1'b0);
      chk("abort_strobes", 32'(stb_seen - s0), 32'd0);
      chk("abort_reg7", 32'(rg(7)), 32'h00);
      set_tx(8'h40, 8'h07, 8'h5A, 8'h00, 8'h00);
      run_frame(3, 0, 1'b0);
      chk("after_abort_reg7", 32'(rg(7)), 32'h5A);

      // SPI commit and fabric load in the same cycle
      coll_addr = 8'h02; coll_data = 8'h66;
      set_tx(8'h40, 8'h02, 8'h99, 8'h00, 8'h00);
      run_frame(3, 0, 1'b1);
      chk("coll_same_reg2", 32'(rg(2)), 32'h99);
      coll_addr = 8'h0A; coll_data = 8'h34;
      set_tx(8'h40, 8'h09, 8'h12, 8'h00, 8'h00);
      run_frame(3, 0, 1'b1);
      chk("coll_diff_reg9", 32'(rg(9)), 32'h12);
      chk("coll_diff_reg10", 32'(rg(10)), 32'h34);

      // reset in the middle of a read data byte
      quiet = 1'b0;
      s0 = stb_seen;
      csn = 1'b0;
      tick(HALF);
      send_bits(8'h41, 8, 0, 1'b0);
      send_bits(8'h03, 8, 1, 1'b0);
      send_bits(8'hFF, 3, 2, 1'b0);
      chk("oe_before_rst", 32'(miso_oe), 32'd1);
      rst = 1'b1;
      tick(2);
      for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
      chk("mid_rst_miso", 32'(miso), 32'd0);
      chk("mid_rst_oe", 32'(miso_oe), 32'd0);
      chk("mid_rst_stb", 32'(wr_stb), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      for (int k = 0; k < NR; k++) chk($sformatf("mid_rst_reg%0d", k), 32'(rg(k)), 32'd0);
      rst = 1'b0;
      send_bits(8'hFF, 5, 2, 1'b0);
      send_bits(8'hFF, 8, 3, 1'b0);
      chk("no_reengage_oe", 32'(oe_any[3]), 32'd0);
      tick(HALF);
      csn = 1'b1;
      tick(8);
      chk("no_reengage_strobes", 32'(stb_seen - s0), 32'd0);
      quiet = 1'b1;
      tick(4);

      set_tx(8'h40, 8'h01, 8'hC3, 8'h00, 8'h00);
      run_frame(3, 0, 1'b0);
      chk("post_rst_reg1", 32'(rg(1)), 32'hC3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
